// File: rtl/rat_pkg.sv
// Shared types and sizing for the checkpointed rename alias table.
package rat_pkg;
  localparam int RENAME_WIDTH = 4;
  localparam int COMMIT_WIDTH = 4;
  localparam int PHY_REG_NUM  = 64;
  localparam int ARCH_REG_NUM = 32;
  localparam int CKPT_NUM     = 4;

  localparam int PHY_W  = $clog2(PHY_REG_NUM);
  localparam int ARCH_W = $clog2(ARCH_REG_NUM);
  localparam int CKPT_W = $clog2(CKPT_NUM);
  localparam int CNT_W  = $clog2(CKPT_NUM + 1);

  typedef logic [PHY_W-1:0]  phy_id_t;
  typedef logic [ARCH_W-1:0] arch_id_t;
  typedef logic [CKPT_W-1:0] ckpt_id_t;

  typedef struct packed {
    logic [PHY_REG_NUM-1:0] visible;
    logic [PHY_REG_NUM-1:0] alloc_mask;
  } ckpt_entry_t;

  // Ring pointers wrap explicitly so CKPT_NUM need not be a power of two.
  function automatic ckpt_id_t ckpt_inc(input ckpt_id_t i);
    return (int'(i) == CKPT_NUM - 1) ? '0 : i + ckpt_id_t'(1);
  endfunction

  function automatic int ckpt_dist(input ckpt_id_t k, input ckpt_id_t head);
    int d;
    d = int'(k) - int'(head);
    if (d < 0) d = d + CKPT_NUM;
    return d;
  endfunction
endpackage

// File: rtl/rat_ckpt_store.sv
// Checkpoint ring: visible snapshots plus per-checkpoint allocation masks,
// with head/tail/count bookkeeping for push, release, restore and flush.
module rat_ckpt_store
  import rat_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   release_i,
  input  logic                   restore_i,
  input  logic                   flush_i,
  input  logic [CKPT_W-1:0]      restore_id_i,
  input  logic [PHY_REG_NUM-1:0] snap_vis_i,
  input  logic [PHY_REG_NUM-1:0] alloc_i,
  output logic [CKPT_W-1:0]      tail_o,
  output logic                   full_o,
  output logic                   restore_live_o,
  output logic [PHY_REG_NUM-1:0] restore_vis_o,
  output logic [PHY_REG_NUM-1:0] restore_mask_o
);
  ckpt_entry_t      ring_q [CKPT_NUM];
  ckpt_entry_t      ring_d [CKPT_NUM];
  ckpt_id_t         head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rel, push;

  assign full_o         = (count_q == CNT_W'(CKPT_NUM));
  assign tail_o         = tail_q;
  assign restore_live_o = ckpt_dist(restore_id_i, head_q) < int'(count_q);
  assign restore_vis_o  = ring_q[restore_id_i].visible;
  assign restore_mask_o = ring_q[restore_id_i].alloc_mask;
  assign rel            = release_i && (count_q != '0);
  // A release frees the head slot this cycle, so a push may reuse it while full.
  assign push           = push_i && (!full_o || rel);

  always_comb begin
    ring_d  = ring_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (restore_i) begin
      if (restore_live_o) begin
        tail_d  = ckpt_inc(restore_id_i);
        count_d = CNT_W'(ckpt_dist(restore_id_i, head_q) + 1);
        ring_d[restore_id_i].alloc_mask = '0;
        if (rel) begin
          head_d  = ckpt_inc(head_q);
          count_d = count_d - CNT_W'(1);
        end
      end
    end else begin
      for (int i = 0; i < CKPT_NUM; i++)
        if (ckpt_dist(ckpt_id_t'(i), head_q) < int'(count_q))
          ring_d[i].alloc_mask = ring_q[i].alloc_mask | alloc_i;
      if (rel) head_d = ckpt_inc(head_q);
      if (push) begin
        ring_d[tail_q] = '{visible: snap_vis_i, alloc_mask: '0};
        tail_d = ckpt_inc(tail_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(rel);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CKPT_NUM; i++) ring_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ring_q  <= ring_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/rat_ckpt.sv
// CAM-organised rename alias table with branch checkpoints for 1-cycle recovery.
// Optional RAT_READ_BYPASS_EN: source lookups forward from older slots of the same group.
module rat_ckpt
  import rat_pkg::*;
(
  input  logic                                        clk,
  input  logic                                        rst,
  output logic [RENAME_WIDTH-1:0][PHY_W-1:0]          rat_rename_new_phy_id,
  output logic [RENAME_WIDTH-1:0]                     rat_rename_new_phy_id_valid,
  input  logic [RENAME_WIDTH-1:0][PHY_W-1:0]          rename_rat_phy_id,
  input  logic [RENAME_WIDTH-1:0]                     rename_rat_phy_id_valid,
  input  logic [RENAME_WIDTH-1:0][ARCH_W-1:0]         rename_rat_arch_id,
  input  logic                                        rename_rat_map,
  input  logic [RENAME_WIDTH-1:0][2:0][ARCH_W-1:0]    rename_rat_read_arch_id,
  output logic [RENAME_WIDTH-1:0][2:0][PHY_W-1:0]     rat_rename_read_phy_id,
  output logic [PHY_REG_NUM-1:0]                      rat_rename_map_table_valid,
  output logic [PHY_REG_NUM-1:0]                      rat_rename_map_table_visible,
  input  logic                                        rename_rat_ckpt_req,
  output logic [CKPT_W-1:0]                           rat_rename_ckpt_id,
  output logic                                        rat_rename_ckpt_full,
  input  logic                                        branch_rat_ckpt_restore,
  input  logic [CKPT_W-1:0]                           branch_rat_ckpt_restore_id,
  input  logic                                        commit_rat_ckpt_release,
  input  logic [PHY_REG_NUM-1:0]                      commit_rat_map_table_valid,
  input  logic [PHY_REG_NUM-1:0]                      commit_rat_map_table_visible,
  input  logic                                        commit_rat_map_table_restore,
  input  logic [COMMIT_WIDTH-1:0][PHY_W-1:0]          commit_rat_release_phy_id,
  input  logic [COMMIT_WIDTH-1:0]                     commit_rat_release_phy_id_valid,
  input  logic                                        commit_rat_release_map,
  input  logic [COMMIT_WIDTH-1:0][PHY_W-1:0]          commit_rat_commit_phy_id,
  input  logic [COMMIT_WIDTH-1:0]                     commit_rat_commit_phy_id_valid,
  input  logic                                        commit_rat_commit_map
);
  logic [PHY_REG_NUM-1:0]             valid_q, valid_d, vis_q, vis_d, commit_q, commit_d;
  logic [PHY_REG_NUM-1:0][ARCH_W-1:0] map_q, map_d;
  logic [PHY_REG_NUM-1:0]             rel_vec, com_vec, alloc_vec, restore_vis, restore_mask;
  logic [RENAME_WIDTH-1:0]            youngest;
  logic                               restore_live;

  assign rat_rename_map_table_valid   = valid_q;
  assign rat_rename_map_table_visible = vis_q;

  // Phy 0 is the "no mapping" id and is never handed out.
  always_comb begin
    logic [PHY_REG_NUM-1:0] taken;
    taken = '0;
    rat_rename_new_phy_id       = '0;
    rat_rename_new_phy_id_valid = '0;
    for (int s = 0; s < RENAME_WIDTH; s++)
      for (int p = 1; p < PHY_REG_NUM; p++)
        if (!rat_rename_new_phy_id_valid[s] && !valid_q[p] && !taken[p]) begin
          rat_rename_new_phy_id[s]       = PHY_W'(p);
          rat_rename_new_phy_id_valid[s] = 1'b1;
          taken[p]                       = 1'b1;
        end
  end

  always_comb begin
    rat_rename_read_phy_id = '0;
    for (int s = 0; s < RENAME_WIDTH; s++)
      for (int r = 0; r < 3; r++) begin
        for (int p = 0; p < PHY_REG_NUM; p++)
          if (vis_q[p] && map_q[p] == rename_rat_read_arch_id[s][r])
            rat_rename_read_phy_id[s][r] = PHY_W'(p);
`ifdef RAT_READ_BYPASS_EN
        for (int j = 0; j < RENAME_WIDTH; j++)
          if (j < s && rename_rat_phy_id_valid[j] &&
              rename_rat_arch_id[j] == rename_rat_read_arch_id[s][r])
            rat_rename_read_phy_id[s][r] = rename_rat_phy_id[j];
`endif
      end
  end

  always_comb begin
    rel_vec   = '0;
    com_vec   = '0;
    alloc_vec = '0;
    youngest  = '1;
    for (int c = 0; c < COMMIT_WIDTH; c++) begin
      if (commit_rat_release_map && commit_rat_release_phy_id_valid[c])
        rel_vec[commit_rat_release_phy_id[c]] = 1'b1;
      if (commit_rat_commit_map && commit_rat_commit_phy_id_valid[c])
        com_vec[commit_rat_commit_phy_id[c]] = 1'b1;
    end
    for (int s = 0; s < RENAME_WIDTH; s++) begin
      if (rename_rat_map && rename_rat_phy_id_valid[s])
        alloc_vec[rename_rat_phy_id[s]] = 1'b1;
      for (int t = 0; t < RENAME_WIDTH; t++)
        if (t > s && rename_rat_phy_id_valid[t] && rename_rat_arch_id[t] == rename_rat_arch_id[s])
          youngest[s] = 1'b0;
    end
  end

  always_comb begin
    valid_d  = valid_q;
    vis_d    = vis_q;
    commit_d = commit_q;
    map_d    = map_q;
    if (commit_rat_map_table_restore) begin
      valid_d  = commit_rat_map_table_valid;
      vis_d    = commit_rat_map_table_visible;
      commit_d = commit_rat_map_table_valid;
    end else if (branch_rat_ckpt_restore) begin
      if (restore_live) begin
        valid_d = valid_q & ~restore_mask & ~rel_vec;
        vis_d   = restore_vis & valid_d;
      end
    end else begin
      if (rename_rat_map) begin
        for (int s = 0; s < RENAME_WIDTH; s++)
          if (rename_rat_phy_id_valid[s])
            for (int p = 0; p < PHY_REG_NUM; p++)
              if (vis_q[p] && map_q[p] == rename_rat_arch_id[s]) vis_d[p] = 1'b0;
        for (int s = 0; s < RENAME_WIDTH; s++)
          if (rename_rat_phy_id_valid[s]) begin
            valid_d[rename_rat_phy_id[s]]  = 1'b1;
            commit_d[rename_rat_phy_id[s]] = 1'b0;
            map_d[rename_rat_phy_id[s]]    = rename_rat_arch_id[s];
            vis_d[rename_rat_phy_id[s]]    = youngest[s];
          end
      end
      // Releases land after the rename group so a clash resolves to free.
      commit_d = commit_d | com_vec;
      valid_d  = valid_d & ~rel_vec;
      vis_d    = vis_d & ~rel_vec;
    end
  end

  rat_ckpt_store u_store (
    .clk           (clk),
    .rst           (rst),
    .push_i        (rename_rat_ckpt_req && !commit_rat_map_table_restore),
    .release_i     (commit_rat_ckpt_release),
    .restore_i     (branch_rat_ckpt_restore),
    .flush_i       (commit_rat_map_table_restore),
    .restore_id_i  (branch_rat_ckpt_restore_id),
    .snap_vis_i    (vis_d),
    .alloc_i       (alloc_vec),
    .tail_o        (rat_rename_ckpt_id),
    .full_o        (rat_rename_ckpt_full),
    .restore_live_o(restore_live),
    .restore_vis_o (restore_vis),
    .restore_mask_o(restore_mask)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= '0;
      vis_q    <= '0;
      commit_q <= '0;
      for (int p = 0; p < PHY_REG_NUM; p++) map_q[p] <= '0;
      for (int p = 1; p < ARCH_REG_NUM; p++) begin
        valid_q[p]  <= 1'b1;
        vis_q[p]    <= 1'b1;
        commit_q[p] <= 1'b1;
        map_q[p]    <= ARCH_W'(p);
      end
    end else begin
      valid_q  <= valid_d;
      vis_q    <= vis_d;
      commit_q <= commit_d;
      map_q    <= map_d;
    end
  end

  restore_live_a: assert property (@(posedge clk) disable iff (!rst)
    (branch_rat_ckpt_restore && !commit_rat_map_table_restore) |-> restore_live);
endmodule
